input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 18 +
 rtl/debounce_channel.sv | 67 ++++++
 rtl/input_conditioner.sv | 66 ++++++
 tb/tb_input_conditioner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: default sizing and the
// reset levels that make every channel come up in its "idle" state.
package input_conditioner_pkg;

  localparam int DEFAULT_NUM_KEYS        = 4;
  localparam int DEFAULT_NUM_SWITCHES    = 9;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Keys are active-low, so their idle raw level is 1; switches idle at 0.
  localparam logic KEY_RESET_LEVEL    = 1'b1;
  localparam logic SWITCH_RESET_LEVEL = 1'b0;

  function automatic int counter_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: multi-flop synchronizer, stability filter and
// registered rise/fall pulses, all in terms of the raw (uninverted) level.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count;
  logic                   synced;
  logic                   differs;
  logic                   settle;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign differs = (synced != stable);
  // Level accepted on the edge where the last required stable cycle is seen.
  assign settle  = differs && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable     <= RESET_LEVEL;
      count      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= settle && synced;
      fall_pulse <= settle && !synced;
      if (!differs || settle) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      if (settle) begin
        stable <= synced;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw push-buttons and toggle switches into clean levels and
// single-cycle press/release/change pulses, one independent channel per pin.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int NUM_SWITCHES    = DEFAULT_NUM_SWITCHES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                    clkIn,
  input  logic                    resetNIn,
  input  logic [NUM_KEYS-1:0]     keysNIn,
  input  logic [NUM_SWITCHES-1:0] switchesIn,
  output logic [NUM_KEYS-1:0]     keysPressedOut,
  output logic [NUM_KEYS-1:0]     keysPressPulseOut,
  output logic [NUM_KEYS-1:0]     keysReleasePulseOut,
  output logic [NUM_SWITCHES-1:0] switchesOut,
  output logic [NUM_SWITCHES-1:0] switchesChangedPulseOut
);

  logic [NUM_KEYS-1:0]     key_stable;
  logic [NUM_KEYS-1:0]     key_rise;
  logic [NUM_KEYS-1:0]     key_fall;
  logic [NUM_SWITCHES-1:0] sw_stable;
  logic [NUM_SWITCHES-1:0] sw_rise;
  logic [NUM_SWITCHES-1:0] sw_fall;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (KEY_RESET_LEVEL)
    ) u_chan (
      .clk        (clkIn),
      .reset_n    (resetNIn),
      .level      (keysNIn[i]),
      .stable     (key_stable[i]),
      .rise_pulse (key_rise[i]),
      .fall_pulse (key_fall[i])
    );
  end

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_switch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (SWITCH_RESET_LEVEL)
    ) u_chan (
      .clk        (clkIn),
      .reset_n    (resetNIn),
      .level      (switchesIn[i]),
      .stable     (sw_stable[i]),
      .rise_pulse (sw_rise[i]),
      .fall_pulse (sw_fall[i])
    );
  end

  // Channels work on raw key polarity; a falling raw key is a press.
  assign keysPressedOut          = ~key_stable;
  assign keysPressPulseOut       = key_fall;
  assign keysReleasePulseOut     = key_rise;
  assign switchesOut             = sw_stable;
  assign switchesChangedPulseOut = sw_rise | sw_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// plus a DEBOUNCE_CYCLES=1 instance sharing the same stimulus.
module tb_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys_n;
  logic [8:0] sw;

  logic [3:0] pressed, press_p, release_p;
  logic [8:0] sw_out, sw_chg;
  logic [3:0] pressed1, press_p1, release_p1;
  logic [8:0] sw_out1, sw_chg1;

  int vectors = 0;
  int miscompares = 0;

  input_conditioner #(
    .NUM_KEYS(4), .NUM_SWITCHES(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clkIn                   (clk),
    .resetNIn                (rst_n),
    .keysNIn                 (keys_n),
    .switchesIn              (sw),
    .keysPressedOut          (pressed),
    .keysPressPulseOut       (press_p),
    .keysReleasePulseOut     (release_p),
    .switchesOut             (sw_out),
    .switchesChangedPulseOut (sw_chg)
  );

  input_conditioner #(
    .NUM_KEYS(4), .NUM_SWITCHES(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)
  ) dut1 (
    .clkIn                   (clk),
    .resetNIn                (rst_n),
    .keysNIn                 (keys_n),
    .switchesIn              (sw),
    .keysPressedOut          (pressed1),
    .keysPressPulseOut       (press_p1),
    .keysReleasePulseOut     (release_p1),
    .switchesOut             (sw_out1),
    .switchesChangedPulseOut (sw_chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    keys_n = 4'hF;
    sw     = 9'h1FF;
    step(3);
    check("rst_pressed", pressed, 0);
    check("rst_press_p", press_p, 0);
    check("rst_release_p", release_p, 0);
    check("rst_sw_out", sw_out, 0);
    check("rst_sw_chg", sw_chg, 0);

    // Switches held on through reset release: edge 0 is first non-reset edge
    rst_n = 1'b1;
    step(5);
    check("sw_hold_early", sw_out, 9'h000);
    check("sw_hold_early_chg", sw_chg, 9'h000);
    step(1);
    check("sw_hold_level", sw_out, 9'h1FF);
    check("sw_hold_chg", sw_chg, 9'h1FF);
    step(1);
    check("sw_hold_chg_end", sw_chg, 9'h000);
    check("sw_hold_keep", sw_out, 9'h1FF);

    sw = 9'h000;
    step(6);
    check("sw_off_level", sw_out, 9'h000);
    check("sw_off_chg", sw_chg, 9'h1FF);
    step(1);
    check("sw_off_chg_end", sw_chg, 9'h000);

    // Switch 3 chattering every cycle never settles
    for (int i = 0; i < 50; i++) begin
      sw[3] = ~sw[3];
      step(1);
      check("chatter_level", sw_out[3], 1'b0);
      check("chatter_chg", sw_chg[3], 1'b0);
    end
    sw[3] = 1'b0;
    step(6);
    check("chatter_after", sw_out, 9'h000);

    // Key 0 press: first sampled at edge k, level after edge k+5
    keys_n[0] = 1'b0;
    step(2);
    check("d1_early", pressed1, 4'h0);
    step(1);
    check("d1_pressed", pressed1, 4'h1);
    check("d1_press_p", press_p1, 4'h1);
    step(1);
    check("d1_press_p_end", press_p1, 4'h0);
    step(1);
    check("k0_early", pressed, 4'h0);
    check("k0_early_p", press_p, 4'h0);
    step(1);
    check("k0_pressed", pressed, 4'h1);
    check("k0_press_p", press_p, 4'h1);
    check("k0_no_rel", release_p, 4'h0);
    step(1);
    check("k0_press_p_end", press_p, 4'h0);
    check("k0_held", pressed, 4'h1);
    keys_n[0] = 1'b1;
    step(5);
    check("k0_rel_early", pressed, 4'h1);
    step(1);
    check("k0_released", pressed, 4'h0);
    check("k0_rel_p", release_p, 4'h1);
    check("k0_rel_no_press", press_p, 4'h0);
    step(1);
    check("k0_rel_p_end", release_p, 4'h0);

    // Key 1 glitch of 3 sampled edges is filtered out
    keys_n[1] = 1'b0;
    step(3);
    keys_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("k1_glitch_level", pressed, 4'h0);
      check("k1_glitch_press", press_p, 4'h0);
      check("k1_glitch_rel", release_p, 4'h0);
    end

    // Key 1 low for exactly 4 sampled edges is accepted
    keys_n[1] = 1'b0;
    step(4);
    keys_n[1] = 1'b1;
    step(1);
    check("k1_4_early", pressed, 4'h0);
    step(1);
    check("k1_4_pressed", pressed, 4'h2);
    check("k1_4_press_p", press_p, 4'h2);
    step(3);
    check("k1_4_still", pressed, 4'h2);
    check("k1_4_no_rel", release_p, 4'h0);
    step(1);
    check("k1_4_released", pressed, 4'h0);
    check("k1_4_rel_p", release_p, 4'h2);
    step(1);
    check("k1_4_rel_p_end", release_p, 4'h0);

    // All four keys on the same edge
    keys_n = 4'h0;
    step(6);
    check("all_pressed", pressed, 4'hF);
    check("all_press_p", press_p, 4'hF);
    check("all_no_rel", release_p, 4'h0);
    step(1);
    check("all_press_p_end", press_p, 4'h0);
    keys_n = 4'hF;
    step(6);
    check("all_released", pressed, 4'h0);
    check("all_rel_p", release_p, 4'hF);
    step(1);
    check("all_rel_p_end", release_p, 4'h0);

    // Key 2 reset mid-debounce (counter = 2) discards the partial count
    keys_n[2] = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_pressed", pressed, 4'h0);
    check("mid_rst_press_p", press_p, 4'h0);
    check("mid_rst_rel_p", release_p, 4'h0);
    check("mid_rst_sw", sw_out, 9'h000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("restart_level", pressed, 4'h0);
      check("restart_press_p", press_p, 4'h0);
    end
    step(1);
    check("restart_pressed", pressed, 4'h4);
    check("restart_press_p", press_p, 4'h4);
    step(1);
    check("restart_p_end", press_p, 4'h0);
    keys_n = 4'hF;
    step(6);
    check("restart_released", release_p, 4'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
